// File: rtl/wildcard_decoder_if.sv
// Bus bundle for wildcard_decoder: table programming, input/output handshakes
// and the event counters. Clock and reset stay outside as plain ports.
interface wildcard_decoder_if #(
  parameter int IN_W    = 3,
  parameter int OUT_W   = 2,
  parameter int ENTRIES = 4,
  parameter int CNT_W   = 8
) ();
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [IN_W-1:0]  cfg_value;
  logic [IN_W-1:0]  cfg_care;
  logic [OUT_W-1:0] cfg_code;
  logic             cfg_en;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [OUT_W-1:0] default_code;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_code;
  logic [IDX_W-1:0] out_idx;
  logic             out_hit;
  logic             out_multi;

  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] multi_cnt;
  logic             clr_cnt;

  modport master (
    output cfg_we, cfg_idx, cfg_value, cfg_care, cfg_code, cfg_en,
    output in_valid, in_data, default_code, out_ready, clr_cnt,
    input  in_ready, out_valid, out_code, out_idx, out_hit, out_multi,
    input  miss_cnt, multi_cnt
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_value, cfg_care, cfg_code, cfg_en,
    input  in_valid, in_data, default_code, out_ready, clr_cnt,
    output in_ready, out_valid, out_code, out_idx, out_hit, out_multi,
    output miss_cnt, multi_cnt
  );
endinterface

// File: rtl/wildcard_decoder.sv
// Programmable ternary-pattern opcode decoder with a one-deep registered result
// stage, lowest-index match selection and saturating miss/multi-match counters.
module wildcard_decoder #(
  parameter int IN_W          = 3,
  parameter int OUT_W         = 2,
  parameter int ENTRIES       = 4,
  parameter int PRIORITY_MODE = 0,
  parameter int CNT_W         = 8
) (
  input logic               clk,
  input logic               rst_n,
  wildcard_decoder_if.slave bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] tbl_en;
  logic [IN_W-1:0]    tbl_value [ENTRIES];
  logic [IN_W-1:0]    tbl_care  [ENTRIES];
  logic [OUT_W-1:0]   tbl_code  [ENTRIES];

  logic [ENTRIES-1:0] match_vec;
  logic               hit;
  logic               multi_raw;
  logic               multi;
  logic [IDX_W-1:0]   win_idx;
  logic [OUT_W-1:0]   win_code;

  logic               in_ready;
  logic               accept;

  logic               out_valid_q;
  logic [OUT_W-1:0]   out_code_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic               out_hit_q;
  logic               out_multi_q;
  logic [CNT_W-1:0]   miss_cnt_q;
  logic [CNT_W-1:0]   multi_cnt_q;

  // An out-of-range cfg_idx never equals any loop index, so it writes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_en[i]    <= 1'b0;
        tbl_value[i] <= '0;
        tbl_care[i]  <= '0;
        tbl_code[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) begin
          tbl_en[i]    <= bus.cfg_en;
          tbl_value[i] <= bus.cfg_value;
          tbl_care[i]  <= bus.cfg_care;
          tbl_code[i]  <= bus.cfg_code;
        end
      end
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_vec[i] = tbl_en[i] &&
                     (((bus.in_data ^ tbl_value[i]) & tbl_care[i]) == '0);
    end
  end

  // Scanning downward lets the lowest matching index win.
  always_comb begin
    hit      = 1'b0;
    win_idx  = '0;
    win_code = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit      = 1'b1;
        win_idx  = IDX_W'(i);
        win_code = tbl_code[i];
      end
    end
  end

  always_comb begin
    logic seen;
    seen      = 1'b0;
    multi_raw = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match_vec[i]) begin
        if (seen) begin
          multi_raw = 1'b1;
        end
        seen = 1'b1;
      end
    end
  end

  assign multi    = (PRIORITY_MODE == 0) ? multi_raw : 1'b0;
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Result stage: load on accept, drop valid once consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_idx_q   <= '0;
      out_hit_q   <= 1'b0;
      out_multi_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_code_q  <= hit ? win_code : bus.default_code;
      out_idx_q   <= hit ? win_idx : '0;
      out_hit_q   <= hit;
      out_multi_q <= multi;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Clear wins over any increment from a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q  <= '0;
      multi_cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      miss_cnt_q  <= '0;
      multi_cnt_q <= '0;
    end else if (accept) begin
      if (!hit && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
      if (multi && (multi_cnt_q != '1)) begin
        multi_cnt_q <= multi_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_hit   = out_hit_q;
  assign bus.out_multi = out_multi_q;
  assign bus.miss_cnt  = miss_cnt_q;
  assign bus.multi_cnt = multi_cnt_q;
endmodule

// File: tb/tb_wildcard_decoder.sv
// Two decoders share one stimulus stream: dut0 in unique-check mode with 8-bit
// counters, dut1 in priority mode with 2-bit counters so saturation shows up early.
module tb_wildcard_decoder;
  localparam int IN_W    = 3;
  localparam int OUT_W   = 2;
  localparam int ENTRIES = 4;
  localparam int IDX_W   = 2;

  typedef struct packed {
    logic [IN_W-1:0]  data;
    logic [OUT_W-1:0] dflt;
    logic [OUT_W-1:0] code;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic             multi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic [IN_W-1:0]  cfg_value = '0;
  logic [IN_W-1:0]  cfg_care = '0;
  logic [OUT_W-1:0] cfg_code = '0;
  logic             cfg_en = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic [OUT_W-1:0] default_code = '0;
  logic             out_ready = 1'b1;
  logic             clr_cnt = 1'b0;

  wildcard_decoder_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ENTRIES(ENTRIES), .CNT_W(8)) bus0 ();
  wildcard_decoder_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ENTRIES(ENTRIES), .CNT_W(2)) bus1 ();

  assign bus0.cfg_we = cfg_we;             assign bus1.cfg_we = cfg_we;
  assign bus0.cfg_idx = cfg_idx;           assign bus1.cfg_idx = cfg_idx;
  assign bus0.cfg_value = cfg_value;       assign bus1.cfg_value = cfg_value;
  assign bus0.cfg_care = cfg_care;         assign bus1.cfg_care = cfg_care;
  assign bus0.cfg_code = cfg_code;         assign bus1.cfg_code = cfg_code;
  assign bus0.cfg_en = cfg_en;             assign bus1.cfg_en = cfg_en;
  assign bus0.in_valid = in_valid;         assign bus1.in_valid = in_valid;
  assign bus0.in_data = in_data;           assign bus1.in_data = in_data;
  assign bus0.default_code = default_code; assign bus1.default_code = default_code;
  assign bus0.out_ready = out_ready;       assign bus1.out_ready = out_ready;
  assign bus0.clr_cnt = clr_cnt;           assign bus1.clr_cnt = clr_cnt;

  wildcard_decoder #(.IN_W(IN_W), .OUT_W(OUT_W), .ENTRIES(ENTRIES),
                     .PRIORITY_MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  wildcard_decoder #(.IN_W(IN_W), .OUT_W(OUT_W), .ENTRIES(ENTRIES),
                     .PRIORITY_MODE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int   passCount = 0;
  int   checkCount = 0;
  int   mMiss0 = 0;
  int   mMulti0 = 0;
  int   mMiss1 = 0;
  vec_t expQ [$];
  vec_t monExp;
  vec_t vecs [8];
  int   waited;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Scoreboard: each completed output transfer pops the oldest expected record.
  always @(negedge clk) begin
    if (rst_n && bus0.out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("dut0_code", 32'(bus0.out_code), 32'(monExp.code));
        checkOutput("dut0_idx", 32'(bus0.out_idx), 32'(monExp.idx));
        checkOutput("dut0_hit", 32'(bus0.out_hit), 32'(monExp.hit));
        checkOutput("dut0_multi", 32'(bus0.out_multi), 32'(monExp.multi));
        checkOutput("dut1_valid", 32'(bus1.out_valid), 32'd1);
        checkOutput("dut1_code", 32'(bus1.out_code), 32'(monExp.code));
        checkOutput("dut1_idx", 32'(bus1.out_idx), 32'(monExp.idx));
        checkOutput("dut1_hit", 32'(bus1.out_hit), 32'(monExp.hit));
        checkOutput("dut1_multi", 32'(bus1.out_multi), 32'd0);
      end
    end
  end

  task automatic writeEntry(input logic [IDX_W-1:0] idx, input logic [IN_W-1:0] value,
                            input logic [IN_W-1:0] care, input logic [OUT_W-1:0] code,
                            input logic en);
    cfg_idx = idx; cfg_value = value; cfg_care = care; cfg_code = code; cfg_en = en;
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Holds in_valid with the vector until accepted; counter models follow each accept.
  task automatic applyStimulus(input vec_t v, input logic clr, output int cycles);
    logic accepted;
    accepted = 1'b0;
    cycles = 0;
    in_valid = 1'b1; in_data = v.data; default_code = v.dflt; clr_cnt = clr;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        accepted = 1'b1;
        expQ.push_back(v);
        if (clr) begin
          mMiss0 = 0; mMulti0 = 0; mMiss1 = 0;
        end else begin
          if (!v.hit) begin
            if (mMiss0 < 255) mMiss0++;
            if (mMiss1 < 3) mMiss1++;
          end
          if (v.multi && mMulti0 < 255) mMulti0++;
        end
      end else begin
        cycles++;
      end
      @(posedge clk); #1;
    end
    clr_cnt = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkCounters(input string tag);
    @(negedge clk);
    checkOutput({tag, "_miss0"}, 32'(bus0.miss_cnt), 32'(mMiss0));
    checkOutput({tag, "_multi0"}, 32'(bus0.multi_cnt), 32'(mMulti0));
    checkOutput({tag, "_miss1"}, 32'(bus1.miss_cnt), 32'(mMiss1));
    checkOutput({tag, "_multi1"}, 32'(bus1.multi_cnt), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    // Table: e0={000,111,11}, e1={000,110,10}, e2={100,110,00}, e3 disabled.
    vecs[0] = '{3'b000, 2'b01, 2'b11, 2'd0, 1'b1, 1'b1};
    vecs[1] = '{3'b001, 2'b01, 2'b10, 2'd1, 1'b1, 1'b0};
    vecs[2] = '{3'b010, 2'b01, 2'b01, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{3'b011, 2'b01, 2'b01, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{3'b100, 2'b01, 2'b00, 2'd2, 1'b1, 1'b0};
    vecs[5] = '{3'b101, 2'b01, 2'b00, 2'd2, 1'b1, 1'b0};
    vecs[6] = '{3'b110, 2'b10, 2'b10, 2'd0, 1'b0, 1'b0};
    vecs[7] = '{3'b111, 2'b01, 2'b01, 2'd0, 1'b0, 1'b0};

    #12;
    checkOutput("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    checkOutput("rst_out_code", 32'(bus0.out_code), 32'd0);
    checkOutput("rst_miss_cnt", 32'(bus1.miss_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    writeEntry(2'd0, 3'b000, 3'b111, 2'b11, 1'b1);
    writeEntry(2'd1, 3'b000, 3'b110, 2'b10, 1'b1);
    writeEntry(2'd2, 3'b100, 3'b110, 2'b00, 1'b1);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], 1'b0, waited);
    in_valid = 1'b0;
    drain();
    checkCounters("table");

    // Backpressure: result for 101 must hold while a miss waits at the input.
    out_ready = 1'b0;
    applyStimulus(vecs[5], 1'b0, waited);
    in_data = vecs[3].data; default_code = vecs[3].dflt;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("hold_in_ready", 32'(bus0.in_ready), 32'd0);
      checkOutput("hold_valid", 32'(bus0.out_valid), 32'd1);
      checkOutput("hold_idx", 32'(bus0.out_idx), 32'd2);
      checkOutput("hold_code", 32'(bus0.out_code), 32'd0);
      checkOutput("hold_hit", 32'(bus0.out_hit), 32'd1);
      checkOutput("hold_miss_cnt", 32'(bus0.miss_cnt), 32'(mMiss0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    applyStimulus(vecs[3], 1'b0, waited);
    checkOutput("release_same_cycle", 32'(waited), 32'd0);
    in_valid = 1'b0;
    drain();
    checkCounters("saturate");

    applyStimulus(vecs[3], 1'b1, waited);
    in_valid = 1'b0;
    drain();
    checkCounters("clr_override");

    // Disabling e2 in the accept cycle must not affect that decode.
    cfg_idx = 2'd2; cfg_value = 3'b100; cfg_care = 3'b110; cfg_code = 2'b00; cfg_en = 1'b0;
    cfg_we = 1'b1;
    applyStimulus(vecs[5], 1'b0, waited);
    cfg_we = 1'b0;
    v = '{3'b101, 2'b01, 2'b01, 2'd0, 1'b0, 1'b0};
    applyStimulus(v, 1'b0, waited);
    in_valid = 1'b0;
    drain();

    // Reset while a result is stalled.
    out_ready = 1'b0;
    applyStimulus(vecs[0], 1'b0, waited);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("pre_reset_multi_cnt", 32'(bus0.multi_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_valid0", 32'(bus0.out_valid), 32'd0);
    checkOutput("async_valid1", 32'(bus1.out_valid), 32'd0);
    checkOutput("async_hit", 32'(bus0.out_hit), 32'd0);
    checkOutput("async_code", 32'(bus0.out_code), 32'd0);
    checkOutput("async_multi", 32'(bus0.out_multi), 32'd0);
    checkOutput("async_multi_cnt", 32'(bus0.multi_cnt), 32'd0);
    checkOutput("async_miss_cnt", 32'(bus0.miss_cnt), 32'd0);
    expQ.delete();
    mMiss0 = 0; mMulti0 = 0; mMiss1 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    v = '{3'b101, 2'b10, 2'b10, 2'd0, 1'b0, 1'b0};
    applyStimulus(v, 1'b0, waited);
    in_valid = 1'b0;
    drain();
    checkCounters("post_reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/wildcard_decoder.md
WILDCARD_DECODER -- requirements
Module: wildcard_decoder

Interface
REQ-001 SHALL: IN_W, 3, opcode input width.
REQ-002 SHALL: OUT_W, 2, decoded code width.
REQ-003 SHALL: ENTRIES, 4, number of programmable pattern entries; IDX_W = max(1,$clog2(ENTRIES)).
REQ-004 SHALL: PRIORITY_MODE, 0, 0 = unique-check mode, 1 = lowest-index priority mode.
REQ-005 SHALL: CNT_W, 8, width of the saturating event counters.
REQ-006 SHALL: one clock; reset is asynchronous and active-low.
REQ-007 SHALL: clk  in  1  clock, all state on rising edge.
REQ-008 SHALL: rst_n  in  1  asynchronous active-low reset.
REQ-009 SHALL: cfg_we  in  1  table write strobe.
REQ-010 SHALL: cfg_idx  in  IDX_W  entry written.
REQ-011 SHALL: cfg_value  in  IN_W  pattern value.
REQ-012 SHALL: cfg_care  in  IN_W  per-bit compare mask (1 = compare, 0 = wildcard).
REQ-013 SHALL: cfg_code  in  OUT_W  code returned on match.
REQ-014 SHALL: cfg_en  in  1  entry enable.
REQ-015 SHALL: in_valid / in_ready  in / out  1  input handshake.
REQ-016 SHALL: in_data  in  IN_W  opcode to decode.
REQ-017 SHALL: default_code  in  OUT_W  code returned on no match.
REQ-018 SHALL: out_valid / out_ready  out / in  1  output handshake.
REQ-019 SHALL: out_code  out  OUT_W; out_idx  out  IDX_W (winning entry, 0 on miss); out_hit  out  1; out_multi  out  1.
REQ-020 SHALL: miss_cnt, multi_cnt  out  CNT_W  event counters; clr_cnt  in  1  synchronous counter clear.

Function
REQ-021 SHALL: entry i matches when en_i=1 and ((in_data ^ value_i) & care_i) == 0.
REQ-022 SHALL: an input is accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-023 SHALL: the decode result is registered; out_valid asserts the cycle after acceptance (latency 1), with full throughput under continuous out_ready.
REQ-024 SHALL: while out_valid && !out_ready, all out_* signals are held stable.
REQ-025 SHALL: with at least one match, out_hit=1, out_idx = lowest matching index, out_code = that entry's code.
REQ-026 SHALL: with no match, out_hit=0, out_idx=0, out_code = default_code sampled at the accept cycle.
REQ-027 SHALL: in PRIORITY_MODE=0, out_multi=1 when two or more entries match; in PRIORITY_MODE=1, out_multi is tied to 0.
REQ-028 SHALL: on each accept, miss_cnt increments on no match and multi_cnt increments when out_multi would be 1; both saturate at 2^CNT_W-1.
REQ-029 SHALL: clr_cnt zeroes both counters next cycle and overrides a same-cycle increment.
REQ-030 SHALL: a cfg_we write takes effect the following cycle; a same-cycle accept decodes against the pre-write table.
REQ-031 SHALL: a cfg_we with cfg_idx >= ENTRIES is ignored.

Reset
REQ-032 SHALL: rst_n low clears all entries (en=0, value=0, care=0, code=0), out_valid=0, out_code=0, out_idx=0, out_hit=0, out_multi=0, miss_cnt=0, multi_cnt=0 immediately, without a clock edge.
REQ-033 SHALL: reset asserted mid-transfer discards any held output; after release, in_ready=1 on the first cycle.

Verification
REQ-034 SHALL: program e0={000,111,11}, e1={000,110,10}, e2={100,110,00}, all enabled; accept 101 -> out_code=00, out_idx=2, out_hit=1, out_multi=0.
REQ-035 SHALL: same table, PRIORITY_MODE=0; accept 000 -> out_code=11, out_idx=0, out_multi=1, multi_cnt=1; with PRIORITY_MODE=1 -> out_multi=0, multi_cnt=0.
REQ-036 SHALL: same table, default_code=01; accept 011 -> out_hit=0, out_code=01, miss_cnt increments by 1.
REQ-037 SHALL: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no counter change; release -> next input accepted the same cycle.
REQ-038 SHALL: with CNT_W=2, drive 5 misses -> miss_cnt=3; assert clr_cnt together with a miss -> miss_cnt=0.
REQ-039 SHALL: assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 and the table is cleared at once; after release, accepting 101 -> out_hit=0, out_code=default_code.
